sub4_rr_arbiter: RTL and testbench
==================================

# sub4_rr_arbiter

Round-robin arbiter and result buffer that shares one 4-bit two's-complement subtractor among `NREQ` requesters. Each requester presents an operand pair under a valid/ready handshake. The block grants one requester per cycle, computes `a - b` with signed-overflow detection, and returns the result through a single registered output stage that carries the requester ID. It sits between the client blocks and the shared subtract datapath and also keeps a saturating count of overflow results for status readout.

## Interface
- `NREQ`, 4, number of requesters (2..8).
- `IDW`, 2, width of `rsp_id`. Must satisfy 2^`IDW` ≥ `NREQ`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid`  in  `NREQ`  per-requester request valid.
- `req_ready`  out  `NREQ`  per-requester grant/accept (combinational).
- `req_a`  in  4*`NREQ`  minuend; requester i uses bits [4i+3:4i].
- `req_b`  in  4*`NREQ`  subtrahend; requester i uses bits [4i+3:4i].
- `rsp_valid`  out  1  result register holds a valid result.
- `rsp_ready`  in  1  downstream accepts the result.
- `rsp_id`  out  `IDW`  index of the requester that owns the result.
- `rsp_diff`  out  4  (a − b) mod 16.
- `rsp_ovf`  out  1  signed overflow of the subtraction.
- `ovf_count`  out  8  saturating count of accepted results with `rsp_ovf`=1.
- `busy`  out  1  equals `rsp_valid` OR any `req_valid`.

## Operation
- Accept enable: `acc_en = !rsp_valid || rsp_ready`. Output stage is a 1-deep pipeline register that can be refilled in the same cycle it drains.
- Arbitration: round-robin pointer `ptr`, reset to 0. When `acc_en`=1, search from `ptr` upward with wrap-around. The first i with `req_valid[i]`=1 is granted.
  - `req_ready[i]`=1 only for the granted index; all other bits are 0.
  - When `acc_en`=0, `req_ready` is all 0.
- On a transfer (`req_valid[g] && req_ready[g]`):
  - Load `rsp_id`=g, `rsp_diff`=`req_a[g]`−`req_b[g]` (mod 16), and `rsp_ovf`=(a[3]^b[3]) & (diff[3]^a[3]).
  - Set `rsp_valid`=1.
  - Set `ptr` = (g+1) mod `NREQ`. The pointer wraps from `NREQ`−1 to 0.
- No transfer in a cycle: `ptr` holds its value.
- Result consumed (`rsp_valid && rsp_ready`) with no new transfer: `rsp_valid`→0. `rsp_id`/`rsp_diff`/`rsp_ovf` hold their last values.
- Simultaneous drain and transfer: the new result replaces the old one and `rsp_valid` stays 1 with no bubble.
- `ovf_count` increments on every transfer whose computed ovf is 1. It saturates at 255 and never wraps.
- Requester rules:
  - Once `req_valid[i]` is raised, `req_a[i]` and `req_b[i]` must stay stable until the handshake completes.
  - `req_valid` may not drop before `req_ready`.
  - The bench flags any violation of these rules. The DUT does not check them.
- Fairness: a continuously asserting requester is granted within `NREQ` transfers.
- Reset (`rst_n`=0 at an edge, including mid-operation): any pending result is discarded, not delivered.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_diff`=0, `rsp_ovf`=0, `ptr`=0, `ovf_count`=0.
  - `req_ready` is forced to 0 while `rst_n`=0.

## Timing
- Latency is 1 cycle: a handshake at edge k makes the result visible with `rsp_valid`=1 immediately after edge k.
- Throughput is 1 result per cycle while `rsp_ready`=1.
- `req_ready` depends combinationally on `req_valid`, `ptr`, `rsp_valid` and `rsp_ready`. There is no combinational path from `req_a`/`req_b` to any output.
- `rsp_*` and `ovf_count` are driven directly from flops.
- Backpressure: while `rsp_valid`=1 and `rsp_ready`=0, all `rsp_*` outputs are frozen and no grant is issued.
- `busy` is combinational.

## Test plan
- Single requester: req0 a=3, b=5, `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_diff`=0xE, `rsp_ovf`=0, `ovf_count`=0.
- Overflow cases:
  - req2 a=0x8, b=0x1 → `rsp_diff`=0x7, `rsp_ovf`=1.
  - Next, req2 a=0x7, b=0xF → `rsp_diff`=0x8, `rsp_ovf`=1, `ovf_count`=2.
- All four requesters valid continuously, `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0,1 on consecutive cycles, with exactly one `req_ready` bit high per cycle.
- Backpressure: hold `rsp_ready`=0 for 3 cycles with req1 and req3 valid → `req_ready`=0 and `rsp_*` frozen. On release, the pending result drains and req1 is granted the same cycle, then req3 next cycle.
- Saturation: 300 overflowing transfers (a=0x8, b=0x1) → `ovf_count` stops at 255.
- Reset mid-operation: assert `rst_n`=0 for one edge while `rsp_valid`=1 and `ptr`=2 → all outputs return to reset values. The first grant afterwards starts the search from requester 0.

Source files
------------

// File: rtl/sub4_rr_arbiter.sv
// Round-robin share of one 4-bit subtractor among NREQ requesters; 1-cycle latency, 1 result/cycle.
// Backpressure: while a result is held (rsp_valid & !rsp_ready) no grant is issued and rsp_* is frozen.
module sub4_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [4*NREQ-1:0] req_a,
   input  logic [4*NREQ-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [3:0]        rsp_diff,
   output logic              rsp_ovf,
   output logic [7:0]        ovf_count,
   output logic              busy
);

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] gnt_idx;
   logic [IDW-1:0] nxt_ptr;
   logic           gnt_hit;
   logic           acc_en;
   logic           xfer;
   logic [3:0]     sel_a;
   logic [3:0]     sel_b;
   logic [3:0]     diff;
   logic           ovf;

   assign acc_en = !rsp_valid || rsp_ready;

   // Walk offsets from the far end so the nearest valid requester after ptr wins.
   always_comb begin
      logic [IDW:0]   sum;
      logic [IDW-1:0] idx;
      gnt_hit = 1'b0;
      gnt_idx = '0;
      sum     = '0;
      idx     = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(NREQ)) begin
            sum = sum - (IDW+1)'(NREQ);
         end
         idx = sum[IDW-1:0];
         if (req_valid[idx]) begin
            gnt_hit = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (rst_n && acc_en && gnt_hit) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   assign xfer    = |req_ready;
   assign nxt_ptr = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

   assign sel_a = req_a[{gnt_idx, 2'b00} +: 4];
   assign sel_b = req_b[{gnt_idx, 2'b00} +: 4];
   assign diff  = sel_a - sel_b;
   assign ovf   = (sel_a[3] ^ sel_b[3]) & (diff[3] ^ sel_a[3]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_diff  <= '0;
         rsp_ovf   <= 1'b0;
         ovf_count <= '0;
      end else begin
         if (xfer) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_idx;
            rsp_diff  <= diff;
            rsp_ovf   <= ovf;
            ptr       <= nxt_ptr;
            if (ovf && (ovf_count != 8'hFF)) begin
               ovf_count <= ovf_count + 8'd1;
            end
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

   assign busy = rsp_valid | (|req_valid);

endmodule

// File: tb/tb_sub4_rr_arbiter.sv
// Randomized scoreboard bench for sub4_rr_arbiter against a queue-based reference model.
module tb_sub4_rr_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [4*NREQ-1:0] req_a;
   logic [4*NREQ-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [3:0]        rsp_diff;
   logic              rsp_ovf;
   logic [7:0]        ovf_count;
   logic              busy;

   sub4_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_diff  (rsp_diff),
      .rsp_ovf   (rsp_ovf),
      .ovf_count (ovf_count),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int id;
      int diff;
      int ovf;
   } exp_t;

   exp_t q[$];
   exp_t last;
   int   n_cmp = 0;
   int   n_err = 0;
   int   exp_cnt = 0;
   int   ptr_m = 0;
   bit   started = 0;

   bit       pv [NREQ];
   logic [3:0] pa [NREQ];
   logic [3:0] pb [NREQ];
   int       wt [NREQ];

   function automatic void chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   task automatic offer(input int i, input int a, input int b);
      if (!pv[i]) begin
         pv[i] = 1'b1;
         pa[i] = 4'(a);
         pb[i] = 4'(b);
      end
   endtask

   // One clock: drive at posedge+1, predict the grant just after negedge, return at posedge+1.
   task automatic step(input bit rdy, input bit rst);
      int   g;
      int   sa;
      int   sb;
      int   r;
      int   exp_rdy;
      exp_t e;
      rst_n     = !rst;
      rsp_ready = rdy;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]       = pv[i];
         req_a[4*i +: 4]    = pa[i];
         req_b[4*i +: 4]    = pb[i];
      end
      @(negedge clk);
      #1;
      g = -1;
      if (!rst && (q.size() == 0 || rdy)) begin
         for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && pv[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
         end
      end
      exp_rdy = (g >= 0) ? (1 << g) : 0;
      chk("req_ready", int'(req_ready), exp_rdy);
      if (rst) begin
         ptr_m   = 0;
         exp_cnt = 0;
         for (int i = 0; i < NREQ; i++) wt[i] = 0;
      end else if (g >= 0) begin
         sa = (int'(pa[g]) > 7) ? int'(pa[g]) - 16 : int'(pa[g]);
         sb = (int'(pb[g]) > 7) ? int'(pb[g]) - 16 : int'(pb[g]);
         r  = sa - sb;
         e.id   = g;
         e.diff = r & 15;
         e.ovf  = (r > 7 || r < -8) ? 1 : 0;
         q.push_back(e);
         if (e.ovf == 1 && exp_cnt < 255) exp_cnt++;
         chk("fairness", (wt[g] < NREQ) ? 1 : 0, 1);
         for (int i = 0; i < NREQ; i++) begin
            if (i != g && pv[i]) wt[i]++;
         end
         wt[g] = 0;
         pv[g] = 1'b0;
         ptr_m = (g + 1) % NREQ;
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares the output register against the scoreboard every negedge.
   initial begin
      bit exp_v;
      last = '{0, 0, 0};
      forever begin
         @(negedge clk);
         if (started) begin
            exp_v = (q.size() != 0);
            chk("rsp_valid", int'(rsp_valid), int'(exp_v));
            chk("busy", int'(busy), int'(exp_v || (|req_valid)));
            chk("ovf_count", int'(ovf_count), exp_cnt);
            if (exp_v) begin
               chk("rsp_id", int'(rsp_id), q[0].id);
               chk("rsp_diff", int'(rsp_diff), q[0].diff);
               chk("rsp_ovf", int'(rsp_ovf), q[0].ovf);
               if (rsp_ready) begin
                  last = q[0];
                  void'(q.pop_front());
               end
            end else begin
               chk("hold_id", int'(rsp_id), last.id);
               chk("hold_diff", int'(rsp_diff), last.diff);
               chk("hold_ovf", int'(rsp_ovf), last.ovf);
            end
            if (!rst_n) begin
               q.delete();
               last = '{0, 0, 0};
            end
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      rsp_ready = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      for (int i = 0; i < NREQ; i++) begin
         pv[i] = 1'b0;
         pa[i] = '0;
         pb[i] = '0;
         wt[i] = 0;
      end
      @(posedge clk);
      #1;
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      started = 1'b1;

      // single requester, then the two overflow corners on req2
      offer(0, 3, 5);     step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      offer(2, 8, 1);     step(1'b1, 1'b0);
      offer(2, 7, 15);    step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      offer(3, 1, 1);     step(1'b1, 1'b0);

      // all four requesters continuously valid
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < NREQ; i++) offer(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
         step(1'b1, 1'b0);
      end
      for (int c = 0; c < 4; c++) step(1'b1, 1'b0);

      // backpressure with req1 and req3 waiting
      offer(0, 5, 2);
      offer(1, 9, 4);
      offer(3, 2, 6);
      step(1'b1, 1'b0);
      for (int c = 0; c < 3; c++) step(1'b0, 1'b0);
      for (int c = 0; c < 4; c++) step(1'b1, 1'b0);

      // overflow counter saturation
      for (int c = 0; c < 300; c++) begin
         offer(0, 8, 1);
         step(1'b1, 1'b0);
      end
      step(1'b1, 1'b0);

      // reset while a result is pending and ptr is 2
      offer(1, 4, 9);     step(1'b1, 1'b0);
      offer(3, 6, 6);     step(1'b0, 1'b1);
      offer(0, 2, 1);     step(1'b1, 1'b0);
      step(1'b1, 1'b0);

      // random traffic with random backpressure
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 9) < 4) offer(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
         end
         step(($urandom_range(0, 3) != 0), 1'b0);
      end

      for (int c = 0; c < 10; c++) step(1'b1, 1'b0);
      chk("drain_queue", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
